// File: rtl/mult_stage_pkg.sv
// mult_stage_pkg: shared state encoding, settle counter sizing and settle range helpers.
package mult_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam int CNT_W      = 4;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;

  // Out-of-range settle values are clamped so the counter can never wrap.
  function automatic logic [CNT_W-1:0] settle_load(input int s);
    return (s < SETTLE_MIN) ? '0 :
           (s > SETTLE_MAX) ? CNT_W'(SETTLE_MAX - 1) : CNT_W'(s - 1);
  endfunction

endpackage

// File: rtl/mult_settle_timer.sv
// mult_settle_timer: loadable down-counter that pulses done when it has counted down to zero.
module mult_settle_timer
  import mult_stage_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         run_q, run_d;

  always_comb begin
    cnt_d = load ? load_val : (run_q && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    run_d = load ? 1'b1 : (run_q && cnt_q != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done = run_q && cnt_q == '0;

endmodule

// File: rtl/mult_operand_launch_capture.sv
// mult_operand_launch_capture: launches operands onto an external multiplier, waits a fixed
// settle time, then captures and presents the product; zero operands bypass the multiplier.
module mult_operand_launch_capture
  import mult_stage_pkg::*;
#(
  parameter int M         = 4,
  parameter int N         = 4,
  parameter int SETTLE    = 2,
  parameter int ZERO_SKIP = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic [M-1:0]   mult_a,
  output logic [N-1:0]   mult_b,
  input  logic [M+N-1:0] mult_product,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M+N-1:0] out_product,
  output logic           out_skipped,
  output logic           busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL = settle_load(SETTLE);

  state_t         state_q, state_d;
  logic [M-1:0]   mult_a_q, mult_a_d;
  logic [N-1:0]   mult_b_q, mult_b_d;
  logic [M+N-1:0] out_product_q, out_product_d;
  logic           out_valid_q, out_valid_d;
  logic           out_skipped_q, out_skipped_d;
  logic           accept, skip, load, done;

  assign in_ready = state_q == ST_IDLE || (state_q == ST_HOLD && out_ready);
  assign accept   = in_valid && in_ready;
  assign skip     = ZERO_SKIP != 0 && (in_a == '0 || in_b == '0);

  mult_settle_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (LOAD_VAL),
    .done     (done)
  );

  // A retiring HOLD result and a new accept resolve in the same edge, so no bubble is needed.
  always_comb begin
    state_d       = state_q;
    mult_a_d      = mult_a_q;
    mult_b_d      = mult_b_q;
    out_product_d = out_product_q;
    out_valid_d   = out_valid_q;
    out_skipped_d = out_skipped_q;
    load          = 1'b0;
    if (state_q == ST_HOLD && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ST_IDLE;
    end
    if (accept && skip) begin
      out_product_d = '0;
      out_skipped_d = 1'b1;
      out_valid_d   = 1'b1;
      state_d       = ST_HOLD;
    end else if (accept) begin
      mult_a_d      = in_a;
      mult_b_d      = in_b;
      out_valid_d   = 1'b0;
      out_skipped_d = 1'b0;
      load          = 1'b1;
      state_d       = ST_SETTLE;
    end
    if (state_q == ST_SETTLE && done) begin
      out_product_d = mult_product;
      out_valid_d   = 1'b1;
      state_d       = ST_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mult_a_q      <= '0;
      mult_b_q      <= '0;
      out_product_q <= '0;
      out_valid_q   <= 1'b0;
      out_skipped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mult_a_q      <= mult_a_d;
      mult_b_q      <= mult_b_d;
      out_product_q <= out_product_d;
      out_valid_q   <= out_valid_d;
      out_skipped_q <= out_skipped_d;
    end
  end

  assign mult_a      = mult_a_q;
  assign mult_b      = mult_b_q;
  assign out_product = out_product_q;
  assign out_valid   = out_valid_q;
  assign out_skipped = out_skipped_q;
  assign busy        = state_q != ST_IDLE;

endmodule

// File: tb/tb_mult_operand_launch_capture.sv
// tb_mult_operand_launch_capture: directed stimulus with a queue scoreboard and a decoupled result monitor.
module tb_mult_operand_launch_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic [3:0] mult_a;
  logic [3:0] mult_b;
  logic [7:0] mult_product;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_product;
  logic       out_skipped;
  logic       busy;

  int         compared = 0;
  int         mismatched = 0;
  logic [8:0] sbq[$];
  logic [8:0] exp_e;
  int         w;

  always #5 clk = ~clk;

  assign mult_product = 8'(mult_a) * 8'(mult_b);

  mult_operand_launch_capture #(.M(4), .N(4), .SETTLE(2), .ZERO_SKIP(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_product (mult_product),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product),
    .out_skipped  (out_skipped),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input bit push,
                      input logic [7:0] ep, input bit es, output int waited);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      tick(1);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) sbq.push_back({es, ep});
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_result: got product %0d skipped %0b with no result expected", out_product, out_skipped);
      end else begin
        exp_e = sbq.pop_front();
        check("result_product", {24'd0, out_product}, {24'd0, exp_e[7:0]});
        check("result_skipped", {31'd0, out_skipped}, {31'd0, exp_e[8]});
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom);
      in_a      = 4'($urandom);
      in_b      = 4'($urandom);
      out_ready = 1'($urandom);
      tick(1);
    end
    out_ready = 1'b1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mult_a", {28'd0, mult_a}, 32'd0);
    check("rst_mult_b", {28'd0, mult_b}, 32'd0);
    check("rst_out_product", {24'd0, out_product}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick(1);

    send(4'd3, 4'd5, 1'b1, 8'd15, 1'b0, w);
    check("basic_wait", w, 0);
    check("basic_mult_a", {28'd0, mult_a}, 32'd3);
    check("basic_mult_b", {28'd0, mult_b}, 32'd5);
    check("basic_valid_early", {31'd0, out_valid}, 32'd0);
    tick(1);
    check("basic_valid_early2", {31'd0, out_valid}, 32'd0);
    tick(1);
    check("basic_valid_lat", {31'd0, out_valid}, 32'd1);
    check("basic_product", {24'd0, out_product}, 32'd15);
    tick(1);
    check("basic_idle", {31'd0, busy}, 32'd0);

    send(4'd9, 4'd0, 1'b1, 8'd0, 1'b1, w);
    check("skip_mult_a_held", {28'd0, mult_a}, 32'd3);
    check("skip_mult_b_held", {28'd0, mult_b}, 32'd5);
    check("skip_valid", {31'd0, out_valid}, 32'd1);
    check("skip_product", {24'd0, out_product}, 32'd0);
    check("skip_flag", {31'd0, out_skipped}, 32'd1);
    tick(1);

    out_ready = 1'b0;
    send(4'd3, 4'd5, 1'b1, 8'd15, 1'b0, w);
    tick(2);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_product", {24'd0, out_product}, 32'd15);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    check("bp_retired_valid", {31'd0, out_valid}, 32'd0);
    check("bp_retired_idle", {31'd0, busy}, 32'd0);

    send(4'd15, 4'd15, 1'b1, 8'd225, 1'b0, w);
    send(4'd2, 4'd7, 1'b1, 8'd14, 1'b0, w);
    check("b2b_wait1", w, 2);
    send(4'd0, 4'd4, 1'b1, 8'd0, 1'b1, w);
    check("b2b_wait2", w, 2);
    check("b2b_skip_valid", {31'd0, out_valid}, 32'd1);
    tick(2);

    send(4'd6, 4'd6, 1'b0, 8'd0, 1'b0, w);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_mult_a", {28'd0, mult_a}, 32'd0);
    check("mid_rst_product", {24'd0, out_product}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
      tick(1);
    end

    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick(1);
    check("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
